// File: rtl/rx_phase_slicer.sv
// Oversampled symbol slicer: picks one sample per symbol by phase, with a continuous
// energy search that finds the highest-magnitude phase over 2^LOG2_SEARCH symbols.
module rx_phase_slicer #(
    parameter int NB_INPUT    = 8,
    parameter int NBF_INPUT   = 7,
    parameter int OV_SAMP     = 4,
    parameter int LOG2_SEARCH = 10,
    localparam int PW         = (OV_SAMP > 1) ? $clog2(OV_SAMP) : 1
) (
    input  logic                clk,
    input  logic                i_srst,
    input  logic [NB_INPUT-1:0] i_is_data,
    input  logic                i_valid,
    input  logic                i_enb,
    input  logic                i_phase_auto,
    input  logic [PW-1:0]       i_phase_sel,
    output logic                o_symbol,
    output logic                o_sym_valid,
    output logic [PW-1:0]       o_phase,
    output logic                o_lock
);
    localparam int MW = NB_INPUT - 1;
    localparam int AW = MW + LOG2_SEARCH;

    typedef enum logic {SEARCH = 1'b0, TRACK = 1'b1} state_t;

    if (NBF_INPUT >= NB_INPUT) begin : g_frac_check
        $error("NBF_INPUT must be smaller than NB_INPUT");
    end

    state_t                       state_q, state_d;
    logic [PW-1:0]                cnt_q, cnt_d;
    logic [PW-1:0]                phase_q, phase_d;
    logic [PW-1:0]                best_phase_q, best_phase_d;
    logic [LOG2_SEARCH-1:0]       sym_cnt_q, sym_cnt_d;
    logic [OV_SAMP-1:0][AW-1:0]   acc_q, acc_d;
    logic [OV_SAMP-1:0][AW-1:0]   acc_sum;
    logic                         symbol_q, symbol_d;
    logic                         sym_valid_q, sym_valid_d;

    logic          accept, sym_end, win_end, on_phase;
    logic [MW-1:0] mag;
    logic [AW-1:0] best_val;
    logic [PW-1:0] best_idx;

    assign accept   = i_valid & i_enb;
    assign sym_end  = accept && (cnt_q == PW'(OV_SAMP - 1));
    assign win_end  = sym_end && (&sym_cnt_q);
    assign on_phase = accept && (cnt_q == phase_q);

    // The most negative code has no positive twin in MW bits, so it saturates.
    always_comb begin
        mag = i_is_data[MW-1:0];
        if (i_is_data[NB_INPUT-1]) begin
            if (i_is_data[MW-1:0] == '0) mag = '1;
            else                         mag = ~i_is_data[MW-1:0] + 1'b1;
        end
    end

    // Argmax sees the window including the closing sample; strict '>' keeps ties low.
    always_comb begin
        best_val = '0;
        best_idx = '0;
        for (int i = 0; i < OV_SAMP; i++) begin
            acc_sum[i] = acc_q[i] + ((cnt_q == PW'(i)) ? AW'(mag) : '0);
        end
        best_val = acc_sum[0];
        for (int i = 1; i < OV_SAMP; i++) begin
            if (acc_sum[i] > best_val) begin
                best_val = acc_sum[i];
                best_idx = PW'(i);
            end
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        phase_d      = phase_q;
        best_phase_d = best_phase_q;
        sym_cnt_d    = sym_cnt_q;
        acc_d        = acc_q;
        symbol_d     = symbol_q;
        sym_valid_d  = 1'b0;
        if (accept) begin
            cnt_d = sym_end ? '0 : cnt_q + 1'b1;
            acc_d = win_end ? '0 : acc_sum;
            if (on_phase) begin
                symbol_d    = i_is_data[NB_INPUT-1];
                sym_valid_d = 1'b1;
            end
            if (sym_end) begin
                phase_d   = i_phase_auto ? best_phase_q : i_phase_sel;
                sym_cnt_d = win_end ? '0 : sym_cnt_q + 1'b1;
            end
            if (win_end) best_phase_d = best_idx;
        end
    end

    always_ff @(posedge clk or posedge i_srst) begin
        if (i_srst) begin
            cnt_q        <= '0;
            phase_q      <= '0;
            best_phase_q <= '0;
            sym_cnt_q    <= '0;
            acc_q        <= '0;
            symbol_q     <= 1'b0;
            sym_valid_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            best_phase_q <= best_phase_d;
            sym_cnt_q    <= sym_cnt_d;
            acc_q        <= acc_d;
            symbol_q     <= symbol_d;
            sym_valid_q  <= sym_valid_d;
        end
    end

    always_ff @(posedge clk or posedge i_srst) begin
        if (i_srst) state_q <= SEARCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == SEARCH && win_end) state_d = TRACK;
    end

    always_comb begin
        o_lock = (state_q == TRACK);
    end

    assign o_symbol    = symbol_q;
    assign o_sym_valid = sym_valid_q;
    assign o_phase     = phase_q;

endmodule

// File: tb/tb_rx_phase_slicer.sv
// Scoreboard bench for rx_phase_slicer: driver pushes expected decisions, monitor checks them.
module tb_rx_phase_slicer;
    logic       clk = 1'b0;
    logic       i_srst = 1'b1;
    logic [7:0] i_is_data = '0;
    logic       i_valid = 1'b0;
    logic       i_enb = 1'b0;
    logic       i_phase_auto = 1'b0;
    logic [1:0] i_phase_sel = '0;
    logic       o_symbol, o_sym_valid, o_lock;
    logic [1:0] o_phase;

    rx_phase_slicer #(.NB_INPUT(8), .NBF_INPUT(7), .OV_SAMP(4), .LOG2_SEARCH(4)) dut (
        .clk(clk), .i_srst(i_srst), .i_is_data(i_is_data), .i_valid(i_valid),
        .i_enb(i_enb), .i_phase_auto(i_phase_auto), .i_phase_sel(i_phase_sel),
        .o_symbol(o_symbol), .o_sym_valid(o_sym_valid), .o_phase(o_phase), .o_lock(o_lock)
    );

    always #5 clk = ~clk;

    typedef struct {logic sym; int edge_n;} exp_t;
    exp_t q[$];
    int   n_cmp = 0, n_bad = 0, cyc = 0;

    // reference state: counts accepted samples only
    int   m_cnt = 0, m_phase = 0, m_best = 0, m_sym = 0, exp_best = 0;
    logic m_lock = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_sym_valid) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL sym_extra: strobe sym=%0b at edge %0d, required no strobe", o_symbol, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.sym !== o_symbol || e.edge_n != cyc) begin
                    n_bad++;
                    $display("FAIL sym: got sym=%0b edge=%0d, required sym=%0b edge=%0d",
                             o_symbol, cyc, e.sym, e.edge_n);
                end
            end
        end else if (q.size() > 0 && q[0].edge_n <= cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sym_missing: no strobe at edge %0d, required sym=%0b", cyc, q[0].sym);
            void'(q.pop_front());
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic v, input logic e);
        i_is_data = d;
        i_valid   = v;
        i_enb     = e;
        if (v && e) begin
            if (m_cnt == m_phase) q.push_back('{d[7], cyc + 1});
            if (m_cnt == 3) begin
                m_phase = i_phase_auto ? m_best : int'(i_phase_sel);
                m_sym++;
                if (m_sym == 16) begin
                    m_sym  = 0;
                    m_best = exp_best;
                    m_lock = 1'b1;
                end
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        if (v && e) begin
            chk("phase", 32'(o_phase), 32'(m_phase));
            chk("lock", 32'(o_lock), 32'(m_lock));
        end
    endtask

    // Reset is raised between edges, after the monitor has consumed any pending strobe.
    task automatic do_reset();
        @(negedge clk);
        #1;
        i_valid = 1'b0;
        i_srst  = 1'b1;
        #1;
        chk("rst_symbol", 32'(o_symbol), 0);
        chk("rst_valid", 32'(o_sym_valid), 0);
        chk("rst_phase", 32'(o_phase), 0);
        chk("rst_lock", 32'(o_lock), 0);
        chk("rst_symcnt", 32'(dut.sym_cnt_q), 0);
        chk("rst_acc0", 32'(dut.acc_q[0]), 0);
        @(posedge clk);
        #1;
        i_srst = 1'b0;
        m_cnt = 0; m_phase = 0; m_best = 0; m_sym = 0; m_lock = 1'b0;
    endtask

    function automatic logic [7:0] auto_val(input int k);
        if (k % 4 == 3) return ((k / 4) % 3 == 0) ? 8'h9C : 8'd100;
        return ((k * 7) % 5 < 2) ? 8'hF6 : 8'd10;
    endfunction

    task automatic run_auto(input bit stall, input int nsamp);
        exp_best     = 3;
        i_phase_auto = 1'b1;
        for (int k = 0; k < nsamp; k++) begin
            if (stall && $urandom_range(0, 2) == 0) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                    if ($urandom_range(0, 1) == 1) send(8'h80, 1'b1, 1'b0);
                    else                           send(8'h80, 1'b0, 1'b1);
                end
            end
            send(auto_val(k), 1'b1, 1'b1);
            if (k == 62) chk("auto_prelock", 32'(o_lock), 0);
            if (k == 63) begin
                chk("auto_lock", 32'(o_lock), 1);
                chk("auto_best", 32'(dut.best_phase_q), 3);
                chk("auto_phase_hold", 32'(o_phase), 0);
            end
            if (k == 67) chk("auto_phase_new", 32'(o_phase), 3);
        end
    endtask

    initial begin
        do_reset();

        // manual slicing at phase 2: one phase-0 symbol while o_phase loads, then +64,-64,+64,-64
        i_phase_auto = 1'b0;
        i_phase_sel  = 2'd2;
        for (int k = 0; k < 20; k++) begin
            logic [7:0] d;
            d = 8'd0;
            if (k >= 4 && k % 4 == 2) d = ((k / 4) % 2 == 1) ? 8'd64 : 8'hC0;
            send(d, 1'b1, 1'b1);
        end
        do_reset();

        // auto lock, then an asynchronous reset in the middle of the second window
        run_auto(1'b0, 80);
        chk("pre_rst_lock", 32'(o_lock), 1);
        do_reset();

        // every sample saturates: all phases tie, lowest index wins
        exp_best     = 0;
        i_phase_auto = 1'b1;
        for (int k = 0; k < 68; k++) begin
            send(8'h80, 1'b1, 1'b1);
            if (k == 62) begin
                chk("sat_acc0", 32'(dut.acc_q[0]), 2032);
                chk("sat_acc1", 32'(dut.acc_q[1]), 2032);
                chk("sat_acc2", 32'(dut.acc_q[2]), 2032);
                chk("sat_acc3", 32'(dut.acc_q[3]), 1905);
            end
            if (k == 63) begin
                chk("sat_lock", 32'(o_lock), 1);
                chk("sat_best", 32'(dut.best_phase_q), 0);
                chk("sat_acc_clr", 32'(dut.acc_q[3]), 0);
            end
        end
        chk("sat_phase", 32'(o_phase), 0);
        chk("sat_symbol", 32'(o_symbol), 1);
        do_reset();

        // same auto stream with valid gaps and enable stalls
        run_auto(1'b1, 80);
        do_reset();

        // phase 1 -> 3 switch requested at cnt=1 of the third symbol
        i_phase_auto = 1'b0;
        i_phase_sel  = 2'd1;
        for (int k = 0; k < 28; k++) begin
            if (k == 9) i_phase_sel = 2'd3;
            send((((k * 5 + k / 4) % 3) == 0) ? 8'hEC : 8'd20, 1'b1, 1'b1);
        end

        for (int k = 0; k < 4; k++) send(8'd0, 1'b0, 1'b0);
        chk("drain", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
